apb_rr_arbiter: RTL and testbench

- Shares a single APB master port between NUM_REQ local requesters using round-robin arbitration.
- Latches the winning requester's command and runs a complete APB SETUP/ACCESS transfer, including wait states, slave error and timeout.
- Returns read data and completion status to that requester.
- Sits between internal command sources and the APB bus.

---
 rtl/apb_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_apb_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ local
// requesters, running full SETUP/ACCESS transfers with wait states, slave error and timeout.
//
// state  | meaning
// IDLE   | bus quiet; arbitrate among eligible requesters, latch winner's command
// SETUP  | psel high for one cycle, bus fields driven from the latched command
// ACCESS | psel and penable high; wait for pready or the wait-state timeout
module apb_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0]        req_write_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      err_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic [ADDR_W-1:0]         paddr_o,
   output logic                      pwrite_o,
   output logic [DATA_W-1:0]         pwdata_o,
   input  logic                      pready_i,
   input  logic [DATA_W-1:0]         prdata_i,
   input  logic                      pslverr_i
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;

   logic [1:0]         state;
   logic [PTR_W-1:0]   ptr;
   logic [CNT_W-1:0]   wait_cnt;
   logic [CNT_W-1:0]   wait_cnt_inc;
   logic               timeout_hit;
   logic               complete;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] rotated;
   logic               found;
   logic [PTR_W-1:0]   winner;
   logic [PTR_W-1:0]   ptr_next;
   int                 idx;

   // A requester still holding req_i on its own completion cycle must not win again.
   always_comb begin
      eligible = req_i & ~done_o;
      rotated  = NUM_REQ'({eligible, eligible} >> ptr);
      found    = 1'b0;
      winner   = ptr;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rotated[i]) begin
            found = 1'b1;
            idx   = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            winner = PTR_W'(idx);
         end
      end
      ptr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
   end

   assign wait_cnt_inc = wait_cnt + 1'b1;
   assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt_inc == CNT_W'(TIMEOUT));
   assign complete     = (state == S_ACCESS) && (pready_i || timeout_hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         wait_cnt  <= '0;
         gnt_o     <= '0;
         done_o    <= '0;
         rdata_o   <= '0;
         err_o     <= 1'b0;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
         paddr_o   <= '0;
         pwrite_o  <= 1'b0;
         pwdata_o  <= '0;
      end else begin
         done_o <= '0;
         err_o  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  state    <= S_SETUP;
                  ptr      <= ptr_next;
                  psel_o   <= 1'b1;
                  gnt_o    <= NUM_REQ'(1) << winner;
                  paddr_o  <= req_addr_i[winner*ADDR_W +: ADDR_W];
                  pwrite_o <= req_write_i[winner];
                  pwdata_o <= req_write_i[winner] ? req_wdata_i[winner*DATA_W +: DATA_W] : '0;
               end
            end
            S_SETUP: begin
               state     <= S_ACCESS;
               penable_o <= 1'b1;
               wait_cnt  <= '0;
            end
            S_ACCESS: begin
               if (complete) begin
                  state     <= S_IDLE;
                  done_o    <= gnt_o;
                  err_o     <= pready_i ? pslverr_i : 1'b1;
                  if (pready_i && !pwrite_o) rdata_o <= prdata_i;
                  gnt_o     <= '0;
                  psel_o    <= 1'b0;
                  penable_o <= 1'b0;
                  paddr_o   <= '0;
                  pwrite_o  <= 1'b0;
                  pwdata_o  <= '0;
               end else begin
                  wait_cnt <= wait_cnt_inc;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: reset, round-robin order, wait states,
// slave error, timeout and mid-transfer reset with hand-computed expectations.
module tb_apb_rr_arbiter;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NR-1:0] req = '0;
   logic [NR-1:0] req_write = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR-1:0] gnt;
   logic [NR-1:0] done;
   logic [DW-1:0] rdata;
   logic          err;
   logic          psel;
   logic          penable;
   logic [AW-1:0] paddr;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic          pready = 1'b0;
   logic [DW-1:0] prdata = '0;
   logic          pslverr = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int order_q[$];
   int n_acc;

   apb_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .req_i(req), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .err_o(err),
      .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata),
      .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int oh_idx(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_cmd(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[k]          = w;
      req_addr[k*AW +: AW]  = a;
      req_wdata[k*DW +: DW] = d;
   endtask

   // Each requester drops its request as soon as its done pulse is seen.
   task automatic run_rr(input logic [NR-1:0] pat);
      order_q.delete();
      req     = pat;
      pready  = 1'b1;
      pslverr = 1'b0;
      for (int c = 0; c < 60 && req != '0; c++) begin
         tick();
         if (psel && !penable) order_q.push_back(oh_idx(gnt));
         req = req & ~done;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp4[4];
      int exp2[2];
      exp4 = '{0, 1, 2, 3};
      exp2 = '{1, 3};

      tick();
      tick();
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      rst = 1'b0;

      for (int k = 0; k < NR; k++) set_cmd(k, 1'b0, AW'(32'h10 * k), '0);
      run_rr(4'b1111);
      chk("rr4_len", order_q.size(), 4);
      for (int i = 0; i < order_q.size() && i < 4; i++) chk($sformatf("rr4_%0d", i), order_q[i], exp4[i]);
      run_rr(4'b1010);
      chk("rr2_len", order_q.size(), 2);
      for (int i = 0; i < order_q.size() && i < 2; i++) chk($sformatf("rr2_%0d", i), order_q[i], exp2[i]);

      // single read, requester 0
      set_cmd(0, 1'b0, 32'h0000_0040, '0);
      prdata = 32'hCAFE_0001;
      pready = 1'b1;
      req    = 4'b0001;
      tick();
      chk("rd_setup_psel", psel, 1);
      chk("rd_setup_pen", penable, 0);
      chk("rd_setup_gnt", gnt, 4'b0001);
      chk("rd_setup_paddr", paddr, 32'h40);
      chk("rd_setup_pwrite", pwrite, 0);
      tick();
      chk("rd_access_pen", penable, 1);
      chk("rd_access_done", done, 0);
      tick();
      chk("rd_done", done, 4'b0001);
      chk("rd_rdata", rdata, 32'hCAFE_0001);
      chk("rd_err", err, 0);
      chk("rd_psel_off", psel, 0);
      req = '0;
      tick();
      chk("rd_done_clr", done, 0);
      chk("rd_no_regrant", psel, 0);

      // write with three wait states, requester 2
      set_cmd(2, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
      pready = 1'b0;
      prdata = 32'h1234_5678;
      req    = 4'b0100;
      tick();
      chk("wr_setup_gnt", gnt, 4'b0100);
      chk("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
      chk("wr_setup_pwrite", pwrite, 1);
      for (int a = 1; a <= 4; a++) begin
         tick();
         chk($sformatf("wr_acc%0d_pen", a), penable & psel, 1);
         chk($sformatf("wr_acc%0d_paddr", a), paddr, 32'h100);
         chk($sformatf("wr_acc%0d_pwdata", a), pwdata, 32'hDEAD_BEEF);
         chk($sformatf("wr_acc%0d_pwrite", a), pwrite, 1);
         chk($sformatf("wr_acc%0d_done", a), done, 0);
         if (a == 4) pready = 1'b1;
      end
      tick();
      chk("wr_done", done, 4'b0100);
      chk("wr_err", err, 0);
      chk("wr_rdata_kept", rdata, 32'hCAFE_0001);
      chk("wr_psel_off", psel, 0);
      req = '0;

      // slave error then clean read (pointer now at 3)
      set_cmd(3, 1'b0, 32'h0000_0200, '0);
      pslverr = 1'b1;
      prdata  = 32'h5555_AAAA;
      req     = 4'b1000;
      tick(); tick(); tick();
      chk("serr_done", done, 4'b1000);
      chk("serr_err", err, 1);
      chk("serr_rdata", rdata, 32'h5555_AAAA);
      req     = '0;
      pslverr = 1'b0;
      tick();
      chk("serr_err_clr", err, 0);
      chk("serr_done_clr", done, 0);
      set_cmd(1, 1'b0, 32'h0000_0204, '0);
      prdata = 32'h0BAD_F00D;
      req    = 4'b0010;
      tick(); tick(); tick();
      chk("ok_done", done, 4'b0010);
      chk("ok_err", err, 0);
      chk("ok_rdata", rdata, 32'h0BAD_F00D);
      req = '0;

      // timeout on requester 2 with requester 0 pending (pointer at 2)
      set_cmd(2, 1'b0, 32'h0000_0300, '0);
      set_cmd(0, 1'b0, 32'h0000_0304, '0);
      pready = 1'b0;
      prdata = 32'h0000_0077;
      req    = 4'b0101;
      tick();
      chk("to_setup_gnt", gnt, 4'b0100);
      n_acc = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (psel && penable) n_acc++;
         else break;
      end
      chk("to_cycles", n_acc, 16);
      chk("to_done", done, 4'b0100);
      chk("to_err", err, 1);
      chk("to_psel_off", psel, 0);
      chk("to_rdata_kept", rdata, 32'h0BAD_F00D);
      req    = req & ~done;
      pready = 1'b1;
      tick();
      chk("to_next_gnt", gnt, 4'b0001);
      chk("to_next_psel", psel, 1);
      tick(); tick();
      chk("to_next_done", done, 4'b0001);
      chk("to_next_rdata", rdata, 32'h0000_0077);
      req = '0;

      // reset during ACCESS (pointer at 1)
      set_cmd(2, 1'b1, 32'h0000_0400, 32'h1111_2222);
      pready = 1'b0;
      req    = 4'b0100;
      tick(); tick();
      chk("rm_in_access", penable, 1);
      rst = 1'b1;
      req = 4'b1111;
      tick();
      chk("rm_psel", psel, 0);
      chk("rm_penable", penable, 0);
      chk("rm_gnt", gnt, 0);
      chk("rm_done", done, 0);
      chk("rm_err", err, 0);
      chk("rm_paddr", paddr, 0);
      chk("rm_pwdata", pwdata, 0);
      chk("rm_pwrite", pwrite, 0);
      chk("rm_rdata", rdata, 0);
      rst = 1'b0;
      for (int k = 0; k < NR; k++) set_cmd(k, 1'b0, AW'(32'h20 * k), '0);
      pready = 1'b1;
      tick();
      chk("rm_first_gnt", gnt, 4'b0001);
      chk("rm_no_done", done, 0);
      req = '0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
